// File: rtl/npu_task_sequencer.sv
// npu_task_sequencer
//   Queued task sequencer for the NPU control path. Commands (LOAD, COMPUTE,
//   STORE, NOP) are pushed into a QDEPTH-entry FIFO and executed one at a
//   time; each returns a completion record (id, err).
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_*                      command push port (valid/ready)
//   done_*                     completion record port (valid/ready)
//   dma_*                      DMA request/response port (one read outstanding)
//   gb_*                       global buffer strobe port (read data 1 cycle later)
//   pe_start, pe_done          PE array trigger and completion pulse
//   busy                       FSM active or FIFO non-empty
//   q_count                    FIFO occupancy
module npu_task_sequencer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LEN_W  = 16,
  parameter int unsigned ID_W   = 8,
  parameter int unsigned QDEPTH = 4,
  parameter int unsigned STRIDE = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [2:0]                cmd_opcode,
  input  logic [ADDR_W-1:0]         cmd_src,
  input  logic [ADDR_W-1:0]         cmd_dst,
  input  logic [LEN_W-1:0]          cmd_len,
  input  logic [ID_W-1:0]           cmd_id,
  output logic                      done_valid,
  input  logic                      done_ready,
  output logic [ID_W-1:0]           done_id,
  output logic                      done_err,
  output logic                      dma_req,
  output logic                      dma_we,
  output logic [ADDR_W-1:0]         dma_addr,
  output logic [DATA_W-1:0]         dma_wdata,
  input  logic                      dma_gnt,
  input  logic                      dma_rvalid,
  input  logic [DATA_W-1:0]         dma_rdata,
  output logic                      gb_ce,
  output logic                      gb_we,
  output logic [ADDR_W-1:0]         gb_addr,
  output logic [DATA_W-1:0]         gb_wdata,
  input  logic [DATA_W-1:0]         gb_rdata,
  output logic                      pe_start,
  input  logic                      pe_done,
  output logic                      busy,
  output logic [$clog2(QDEPTH):0]   q_count
);

  localparam int unsigned        PW   = $clog2(QDEPTH);
  localparam logic [PW:0]        FULL = (PW+1)'(QDEPTH);
  localparam logic [ADDR_W-1:0]  STEP = ADDR_W'(STRIDE);

  localparam logic [2:0] OP_LOAD    = 3'b000;
  localparam logic [2:0] OP_COMPUTE = 3'b001;
  localparam logic [2:0] OP_STORE   = 3'b010;
  localparam logic [2:0] OP_NOP     = 3'b111;

  typedef enum logic [2:0] {
    IDLE, LD_REQ, LD_WAIT, ST_RD, ST_WR, PE_WAIT, DONE
  } state_t;

  // Command FIFO
  logic [2:0]        q_op  [QDEPTH];
  logic [ADDR_W-1:0] q_src [QDEPTH];
  logic [ADDR_W-1:0] q_dst [QDEPTH];
  logic [LEN_W-1:0]  q_len [QDEPTH];
  logic [ID_W-1:0]   q_id  [QDEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic              push, pop;

  state_t            state;
  logic [ADDR_W-1:0] src_a, dst_a;
  logic [LEN_W-1:0]  len_r, k, k_nxt;
  logic              more;
  logic [ID_W-1:0]   id_r;
  logic              err_r;
  logic [DATA_W-1:0] held;
  logic              st_first;
  logic              gbw_pend;
  logic [ADDR_W-1:0] gbw_addr;
  logic [DATA_W-1:0] gbw_data;

  assign cmd_ready = (q_count < FULL);
  assign push      = cmd_valid & cmd_ready;
  assign pop       = (state == IDLE) && (q_count != '0);
  assign busy      = (state != IDLE) || (q_count != '0);
  assign pe_start  = pop && (q_op[rd_ptr] == OP_COMPUTE);

  // k < len always holds while a word is in flight, so k+1 cannot overflow
  // even for len = 2^LEN_W-1.
  assign k_nxt = k + 1'b1;
  assign more  = k_nxt < len_r;

  always_ff @(posedge clk) begin
    if (push) begin
      q_op[wr_ptr]  <= cmd_opcode;
      q_src[wr_ptr] <= cmd_src;
      q_dst[wr_ptr] <= cmd_dst;
      q_len[wr_ptr] <= cmd_len;
      q_id[wr_ptr]  <= cmd_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   q_count <= q_count + 1'b1;
        2'b01:   q_count <= q_count - 1'b1;
        default: ;
      endcase
    end
  end

  // Addresses are kept as running pointers stepped by STRIDE per word,
  // which equals base + k*STRIDE modulo 2^ADDR_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      src_a    <= '0;
      dst_a    <= '0;
      len_r    <= '0;
      k        <= '0;
      id_r     <= '0;
      err_r    <= 1'b0;
      held     <= '0;
      st_first <= 1'b0;
      gbw_pend <= 1'b0;
      gbw_addr <= '0;
      gbw_data <= '0;
    end else begin
      gbw_pend <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            src_a <= q_src[rd_ptr];
            dst_a <= q_dst[rd_ptr];
            len_r <= q_len[rd_ptr];
            id_r  <= q_id[rd_ptr];
            k     <= '0;
            err_r <= 1'b0;
            case (q_op[rd_ptr])
              OP_LOAD:    state <= (q_len[rd_ptr] == '0) ? DONE : LD_REQ;
              OP_STORE:   state <= (q_len[rd_ptr] == '0) ? DONE : ST_RD;
              OP_COMPUTE: state <= PE_WAIT;
              OP_NOP:     state <= DONE;
              default: begin
                state <= DONE;
                err_r <= 1'b1;
              end
            endcase
          end
        end
        LD_REQ: begin
          if (dma_gnt) state <= LD_WAIT;
        end
        LD_WAIT: begin
          // The buffer write strobe is issued one cycle after rvalid from
          // registered copies; throughput stays at 2 cycles/word.
          if (dma_rvalid) begin
            gbw_pend <= 1'b1;
            gbw_addr <= dst_a;
            gbw_data <= dma_rdata;
            k        <= k_nxt;
            src_a    <= src_a + STEP;
            dst_a    <= dst_a + STEP;
            state    <= more ? LD_REQ : DONE;
          end
        end
        ST_RD: begin
          st_first <= 1'b1;
          state    <= ST_WR;
        end
        ST_WR: begin
          st_first <= 1'b0;
          if (st_first) held <= gb_rdata;
          if (dma_gnt) begin
            k     <= k_nxt;
            src_a <= src_a + STEP;
            dst_a <= dst_a + STEP;
            state <= more ? ST_RD : DONE;
          end
        end
        PE_WAIT: begin
          if (pe_done) state <= DONE;
        end
        DONE: begin
          if (done_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode only registered state; the single exception is the
  // store write data, which forwards gb_rdata in the cycle it is valid.
  always_comb begin
    dma_req    = 1'b0;
    dma_we     = 1'b0;
    dma_addr   = '0;
    dma_wdata  = '0;
    gb_ce      = 1'b0;
    gb_we      = 1'b0;
    gb_addr    = '0;
    gb_wdata   = '0;
    done_valid = 1'b0;
    done_id    = '0;
    done_err   = 1'b0;
    case (state)
      LD_REQ: begin
        dma_req  = 1'b1;
        dma_addr = src_a;
      end
      ST_RD: begin
        gb_ce   = 1'b1;
        gb_addr = src_a;
      end
      ST_WR: begin
        dma_req   = 1'b1;
        dma_we    = 1'b1;
        dma_addr  = dst_a;
        dma_wdata = st_first ? gb_rdata : held;
      end
      DONE: begin
        done_valid = 1'b1;
        done_id    = id_r;
        done_err   = err_r;
      end
      default: ;
    endcase
    if (gbw_pend) begin
      gb_ce    = 1'b1;
      gb_we    = 1'b1;
      gb_addr  = gbw_addr;
      gb_wdata = gbw_data;
    end
  end

endmodule
